// File: rtl/shift_display_ctrl.sv
// Parametrised shift register with tick generation and a dual-bank
// multiplexed seven-segment display driver, single clock domain.
module shift_display_ctrl #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned SLOW_HZ    = 1,
  parameter int unsigned FAST_HZ    = 12,
  parameter int unsigned SCAN_HZ    = 1000,
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned SHIFT_STEP = 1,
  parameter logic [4*DIGITS-1:0] INIT = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sd,
  input  logic [2:0]            mode,
  input  logic                  sin,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [4*DIGITS-1:0]   q,
  output logic                  step_pulse,
  output logic [7:0]            a_to_g_left,
  output logic [7:0]            a_to_g_right,
  output logic [3:0]            leftseg,
  output logic [3:0]            rightseg
);

  localparam int unsigned WIDTH    = 4 * DIGITS;
  localparam int unsigned S        = SHIFT_STEP;
  localparam int unsigned DIV_SLOW = CLK_HZ / SLOW_HZ;
  localparam int unsigned DIV_FAST = CLK_HZ / FAST_HZ;
  localparam int unsigned DIV_MAX  = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int unsigned CNT_W    = $clog2(DIV_MAX + 1);
  localparam int unsigned SCAN_RAW = CLK_HZ / (SCAN_HZ * 8);
  localparam int unsigned SCAN_P   = (SCAN_RAW < 1) ? 1 : SCAN_RAW;
  localparam int unsigned SCAN_W   = $clog2(SCAN_P + 1);

  logic [WIDTH-1:0]  q_q, q_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sd_q;
  logic              pulse_q, pulse_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        seg_l_q, seg_l_d, seg_r_q, seg_r_d;
  logic [3:0]        an_l_q, an_l_d, an_r_q, an_r_d;
  logic [CNT_W-1:0]  div_last_c;
  logic [31:0]       q_pad_c;
  logic [3:0]        nib_c;
  logic [7:0]        seg_c;

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      4'hF: hex7 = 7'h71;
    endcase
  endfunction

  assign div_last_c = sd_q ? CNT_W'(DIV_FAST - 1) : CNT_W'(DIV_SLOW - 1);

  // Tick counter, shift/load datapath and step pulse.
  always_comb begin
    q_d     = q_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (mode == 3'd5) begin
      q_d   = load_data;
      cnt_d = '0;
    end else if (sd != sd_q) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == div_last_c) begin
        cnt_d = '0;
        case (mode)
          3'd1: begin q_d = {q_q[WIDTH-1-S:0], {S{sin}}};        pulse_d = 1'b1; end
          3'd2: begin q_d = {{S{sin}}, q_q[WIDTH-1:S]};          pulse_d = 1'b1; end
          3'd3: begin q_d = {q_q[WIDTH-1-S:0], q_q[WIDTH-1:WIDTH-S]}; pulse_d = 1'b1; end
          3'd4: begin q_d = {q_q[S-1:0], q_q[WIDTH-1:S]};        pulse_d = 1'b1; end
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Nibble and segment pattern for the slot currently indexed.
  always_comb begin
    q_pad_c = 32'(q_q);
    nib_c   = q_pad_c[{idx_q, 2'b00} +: 4];
    seg_c   = {1'b1, ~hex7(nib_c)};
  end

  // Scan timing: advance slot each digit period and register the bank outputs.
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    seg_l_d    = seg_l_q;
    seg_r_d    = seg_r_q;
    an_l_d     = an_l_q;
    an_r_d     = an_r_q;
    if (scan_cnt_q == SCAN_W'(SCAN_P - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
      seg_l_d    = 8'hFF;
      seg_r_d    = 8'hFF;
      an_l_d     = 4'hF;
      an_r_d     = 4'hF;
      if ({1'b0, idx_q} < 4'(DIGITS)) begin
        if (!idx_q[2]) begin
          seg_r_d = seg_c;
          an_r_d  = ~(4'b0001 << idx_q[1:0]);
        end else begin
          seg_l_d = seg_c;
          an_l_d  = ~(4'b0001 << idx_q[1:0]);
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= INIT;
      cnt_q      <= '0;
      sd_q       <= sd;
      pulse_q    <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_l_q    <= 8'hFF;
      seg_r_q    <= 8'hFF;
      an_l_q     <= 4'hF;
      an_r_q     <= 4'hF;
    end else begin
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      sd_q       <= sd;
      pulse_q    <= pulse_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_l_q    <= seg_l_d;
      seg_r_q    <= seg_r_d;
      an_l_q     <= an_l_d;
      an_r_q     <= an_r_d;
    end
  end

  assign q            = q_q;
  assign step_pulse   = pulse_q;
  assign a_to_g_left  = seg_l_q;
  assign a_to_g_right = seg_r_q;
  assign leftseg      = an_l_q;
  assign rightseg     = an_r_q;

endmodule

// File: tb/tb_shift_display_ctrl.sv
// Directed bench for shift_display_ctrl: one-bit and nibble step instances.
module tb_shift_display_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, sd, sin;
  logic [2:0]  mode;
  logic [15:0] load_data;

  logic [15:0] q1, q4;
  logic        sp1, sp4;
  logic [7:0]  agl1, agr1, agl4, agr4;
  logic [3:0]  ls1, rs1, ls4, rs4;

  int checks = 0;
  int errors = 0;
  bit found;

  always #5 clk = ~clk;

  shift_display_ctrl #(
    .CLK_HZ(120), .SLOW_HZ(1), .FAST_HZ(12), .SCAN_HZ(15),
    .DIGITS(4), .SHIFT_STEP(1), .INIT(16'h0001)
  ) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .sd(sd), .mode(mode), .sin(sin),
    .load_data(load_data), .q(q1), .step_pulse(sp1),
    .a_to_g_left(agl1), .a_to_g_right(agr1), .leftseg(ls1), .rightseg(rs1)
  );

  shift_display_ctrl #(
    .CLK_HZ(120), .SLOW_HZ(1), .FAST_HZ(12), .SCAN_HZ(15),
    .DIGITS(4), .SHIFT_STEP(4), .INIT(16'h0001)
  ) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .sd(sd), .mode(mode), .sin(sin),
    .load_data(load_data), .q(q4), .step_pulse(sp4),
    .a_to_g_left(agl4), .a_to_g_right(agr4), .leftseg(ls4), .rightseg(rs4)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sd = 1'b1; mode = 3'd0; sin = 1'b0; load_data = 16'h0000;
    tick(1);
    rst = 1'b0;
    check("rst_q", 32'(q1), 32'h0001);
    check("rst_pulse", 32'(sp1), 32'h0);
    check("rst_rightseg", 32'(rs1), 32'hF);
    check("rst_leftseg", 32'(ls1), 32'hF);
    check("rst_agr", 32'(agr1), 32'hFF);
    check("rst_agl", 32'(agl1), 32'hFF);

    // rotate left, fast rate
    mode = 3'd3; en = 1'b1;
    tick(9);
    check("rol_pre", 32'(q1), 32'h0001);
    check("rol_pre_pulse", 32'(sp1), 32'h0);
    tick(1);
    check("rol1_q", 32'(q1), 32'h0002);
    check("rol4_q", 32'(q4), 32'h0010);
    check("rol_pulse", 32'(sp1), 32'h1);
    tick(1);
    check("rol_pulse_end", 32'(sp1), 32'h0);
    tick(29);
    check("rol_40", 32'(q1), 32'h0010);

    // shift left slow, freeze 50 clocks mid-count
    mode = 3'd1; sd = 1'b0; sin = 1'b0;
    tick(1);
    tick(60);
    en = 1'b0;
    tick(50);
    en = 1'b1;
    tick(10);
    check("frz_no_early", 32'(q1), 32'h0010);
    tick(49);
    check("frz_edge169", 32'(q1), 32'h0010);
    tick(1);
    check("frz_shift", 32'(q1), 32'h0020);
    check("frz_shift4", 32'(q4), 32'h0010);
    check("frz_pulse", 32'(sp1), 32'h1);

    // speed change at cnt=7 clears the counter
    sd = 1'b1;
    tick(1);
    tick(7);
    sd = 1'b0;
    tick(1);
    tick(2);
    check("sd_no_cnt9", 32'(q1), 32'h0020);
    check("sd_no_pulse", 32'(sp1), 32'h0);
    tick(117);
    check("sd_edge120", 32'(q1), 32'h0020);
    tick(1);
    check("sd_shift", 32'(q1), 32'h0040);
    check("sd_shift4", 32'(q4), 32'h0100);

    // parallel load then shift right with sin=1
    mode = 3'd5; load_data = 16'h1234;
    tick(1);
    check("load1", 32'(q1), 32'h1234);
    check("load4", 32'(q4), 32'h1234);
    check("load_pulse", 32'(sp1), 32'h0);
    mode = 3'd2; sin = 1'b1; sd = 1'b1;
    tick(10);
    check("shr_pre", 32'(q4), 32'h1234);
    tick(1);
    check("shr4", 32'(q4), 32'hF123);
    check("shr1", 32'(q1), 32'h891A);
    check("shr_pulse4", 32'(sp4), 32'h1);

    // scan of 1234
    mode = 3'd5;
    tick(1);
    mode = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick(1);
      if (rs1 == 4'b1110) found = 1'b1;
    end
    check("scan_found", 32'(found), 32'h1);
    check("scan0_agr", 32'(agr1), 32'h99);
    check("scan0_ls", 32'(ls1), 32'hF);
    check("scan0_agl", 32'(agl1), 32'hFF);
    tick(1);
    check("scan1_rs", 32'(rs1), 32'hD);
    check("scan1_agr", 32'(agr1), 32'hB0);
    tick(1);
    check("scan2_rs", 32'(rs1), 32'hB);
    check("scan2_agr", 32'(agr1), 32'hA4);
    tick(1);
    check("scan3_rs", 32'(rs1), 32'h7);
    check("scan3_agr", 32'(agr1), 32'hF9);
    for (int k = 4; k < 8; k++) begin
      tick(1);
      check($sformatf("blank%0d_an", k), 32'({ls1, rs1}), 32'hFF);
      check($sformatf("blank%0d_seg", k), 32'({agl1, agr1}), 32'hFFFF);
    end
    tick(1);
    check("wrap_rs", 32'(rs1), 32'hE);
    check("wrap_agr", 32'(agr1), 32'h99);

    // reset mid-operation overrides load
    mode = 3'd5; en = 1'b1; load_data = 16'hABCD; rst = 1'b1;
    tick(1);
    rst = 1'b0; mode = 3'd0;
    check("rst2_q", 32'(q1), 32'h0001);
    check("rst2_pulse", 32'(sp1), 32'h0);
    check("rst2_an", 32'({ls1, rs1}), 32'hFF);
    check("rst2_seg", 32'({agl1, agr1}), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
